// File: rtl/fp_operand_align.sv
// rtl/fp_operand_align.sv - fetch, classify, order and align an IEEE-754 single operand pair
//
// Fetches one A/B operand pair from the operand memory. A load_data pulse
// requests the pair, and a_in/b_in are captured after FETCH_LAT cycles.
// The block then classifies both operands, orders them by magnitude and
// right-aligns the smaller mantissa with guard/round/sticky bits. The result
// is offered to the add/sub core over a valid/ready handshake.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  request next pair (honoured in IDLE or OUT only)
//   load_data              1-cycle fetch request to operand memory
//   a_in, b_in             operand pair from memory
//   busy                   high in every state except IDLE
//   out_valid, out_ready   result handshake
//   swapped .. class_b     aligned result fields

module fp_operand_align #(
    parameter int FETCH_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        load_data,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        swapped,
    output logic        sign_big,
    output logic        sign_small,
    output logic [7:0]  exp_big,
    output logic [7:0]  exp_diff,
    output logic [26:0] mant_big,
    output logic [26:0] mant_small,
    output logic [3:0]  class_a,
    output logic [3:0]  class_b
);

    localparam int CW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ALIGN,
        S_OUT
    } state_t;

    typedef struct packed {
        logic        swapped;
        logic        sign_big;
        logic        sign_small;
        logic [7:0]  exp_big;
        logic [7:0]  exp_diff;
        logic [26:0] mant_big;
        logic [26:0] mant_small;
        logic [3:0]  class_a;
        logic [3:0]  class_b;
    } res_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           load_data_q, load_data_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    res_t           res_q, res_d;

    // {nan, inf, denorm, zero}; all-zero means a normal number
    function automatic logic [3:0] classify(input logic [31:0] x);
        logic e_zero;
        logic e_ones;
        logic f_zero;
        e_zero = (x[30:23] == 8'h00);
        e_ones = (x[30:23] == 8'hFF);
        f_zero = (x[22:0] == 23'h0);
        return {e_ones & ~f_zero, e_ones & f_zero, e_zero & ~f_zero, e_zero & f_zero};
    endfunction

    // Denormals use exponent 1 with no hidden bit so they share the normal scale
    function automatic logic [7:0] eff_exp(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 8'h01 : x[30:23];
    endfunction

    function automatic logic [26:0] unpack_mant(input logic [31:0] x);
        return {(x[30:23] != 8'h00), x[22:0], 3'b000};
    endfunction

    // Alignment datapath on the captured pair
    logic        swap_c;
    logic [7:0]  exp_big_c;
    logic [7:0]  exp_small_c;
    logic [7:0]  diff_c;
    logic [26:0] m_big_c;
    logic [26:0] m_small_c;
    logic [26:0] lost_mask_c;
    logic [26:0] aligned_c;

    always_comb begin
        // Magnitude compare ignores the sign; ties keep A as the larger operand
        swap_c      = (b_q[30:0] > a_q[30:0]);
        exp_big_c   = swap_c ? eff_exp(b_q) : eff_exp(a_q);
        exp_small_c = swap_c ? eff_exp(a_q) : eff_exp(b_q);
        diff_c      = exp_big_c - exp_small_c;
        m_big_c     = swap_c ? unpack_mant(b_q) : unpack_mant(a_q);
        m_small_c   = swap_c ? unpack_mant(a_q) : unpack_mant(b_q);
        lost_mask_c = ~({27{1'b1}} << diff_c);
        if (diff_c >= 8'd27) begin
            // Everything shifts out; only the sticky survives
            aligned_c = {26'b0, |m_small_c};
        end else begin
            aligned_c = (m_small_c >> diff_c) | {26'b0, |(m_small_c & lost_mask_c)};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_data_d = 1'b0;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_REQ;
                    load_data_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = CW'(FETCH_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = S_ALIGN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ALIGN: begin
                res_d.swapped    = swap_c;
                res_d.sign_big   = swap_c ? b_q[31] : a_q[31];
                res_d.sign_small = swap_c ? a_q[31] : b_q[31];
                res_d.exp_big    = exp_big_c;
                res_d.exp_diff   = diff_c;
                res_d.mant_big   = m_big_c;
                res_d.mant_small = aligned_c;
                res_d.class_a    = classify(a_q);
                res_d.class_b    = classify(b_q);
                out_valid_d      = 1'b1;
                state_d          = S_OUT;
            end
            S_OUT: begin
                // Result fields stay frozen here until the transfer
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d     = S_REQ;
                        load_data_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            load_data_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
        end
    end

    assign load_data  = load_data_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign swapped    = res_q.swapped;
    assign sign_big   = res_q.sign_big;
    assign sign_small = res_q.sign_small;
    assign exp_big    = res_q.exp_big;
    assign exp_diff   = res_q.exp_diff;
    assign mant_big   = res_q.mant_big;
    assign mant_small = res_q.mant_small;
    assign class_a    = res_q.class_a;
    assign class_b    = res_q.class_b;

endmodule

// File: tb/tb_fp_operand_align.sv
// tb/tb_fp_operand_align.sv - directed bench for fp_operand_align (FETCH_LAT 2 and 4)

module tb_fp_operand_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic        out_ready, out_ready4;
    logic [31:0] a_in, b_in;

    logic        load_data, busy, out_valid, swapped, sign_big, sign_small;
    logic [7:0]  exp_big, exp_diff;
    logic [26:0] mant_big, mant_small;
    logic [3:0]  class_a, class_b;

    logic        load_data4, busy4, out_valid4, swapped4, sign_big4, sign_small4;
    logic [7:0]  exp_big4, exp_diff4;
    logic [26:0] mant_big4, mant_small4;
    logic [3:0]  class_a4, class_b4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_operand_align #(.FETCH_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .load_data(load_data),
        .a_in(a_in), .b_in(b_in), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .swapped(swapped), .sign_big(sign_big),
        .sign_small(sign_small), .exp_big(exp_big), .exp_diff(exp_diff),
        .mant_big(mant_big), .mant_small(mant_small),
        .class_a(class_a), .class_b(class_b)
    );

    fp_operand_align #(.FETCH_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .load_data(load_data4),
        .a_in(a_in), .b_in(b_in), .busy(busy4), .out_valid(out_valid4),
        .out_ready(out_ready4), .swapped(swapped4), .sign_big(sign_big4),
        .sign_small(sign_small4), .exp_big(exp_big4), .exp_diff(exp_diff4),
        .mant_big(mant_big4), .mant_small(mant_small4),
        .class_a(class_a4), .class_b(class_b4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that sampled start; counts edges to out_valid
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        int pulses;
        lat    = 0;
        pulses = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            if (load_data) pulses++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_extra_load"}, pulses, 0);
    endtask

    task automatic check_res(input string tag, input logic sw, input logic [7:0] eb,
                             input logic [7:0] ed, input logic [26:0] mb,
                             input logic [26:0] ms, input logic [3:0] ca,
                             input logic [3:0] cb);
        chk({tag, "_valid"},      out_valid, 1);
        chk({tag, "_swapped"},    swapped, sw);
        chk({tag, "_exp_big"},    exp_big, eb);
        chk({tag, "_exp_diff"},   exp_diff, ed);
        chk({tag, "_mant_big"},   mant_big, mb);
        chk({tag, "_mant_small"}, mant_small, ms);
        chk({tag, "_class_a"},    class_a, ca);
        chk({tag, "_class_b"},    class_b, cb);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sw, input logic [7:0] eb, input logic [7:0] ed,
                       input logic [26:0] mb, input logic [26:0] ms,
                       input logic [3:0] ca, input logic [3:0] cb);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_load_pulse"}, load_data, 1);
        chk({tag, "_busy"}, busy, 1);
        wait_valid(tag, 4);
        check_res(tag, sw, eb, ed, mb, ms, ca, cb);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int l2;
        int l4;
        rst        = 1'b1;
        start      = 1'b0;
        start4     = 1'b0;
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        a_in       = '0;
        b_in       = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_load", load_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_mant_big", mant_big, 0);
        chk("rst_exp_big", exp_big, 0);
        chk("rst_class_a", class_a, 0);
        chk("rst_busy4", busy4, 0);
        tick();
        chk("idle_no_load", load_data, 0);

        // Both denormals: exponent 1, no hidden bit
        run("t1", 32'h00000001, 32'h00000002, 1, 8'h01, 8'h00, 27'h10, 27'h08, 4'b0010, 4'b0010);
        accept("t1");
        run("t2", 32'h3F800000, 32'h40000000, 1, 8'h80, 8'h01, 27'h4000000, 27'h2000000, 4'b0000, 4'b0000);
        accept("t2");
        // Shift beyond the mantissa collapses to the sticky bit
        run("t3", 32'h3F800000, 32'h30800000, 0, 8'h7F, 8'h1E, 27'h4000000, 27'h1, 4'b0000, 4'b0000);
        accept("t3");
        run("t4", 32'h7FC00000, 32'h7F800000, 0, 8'hFF, 8'h00, 27'h6000000, 27'h4000000, 4'b1000, 4'b0100);
        accept("t4");
        run("zero", 32'h00000000, 32'h3F800000, 1, 8'h7F, 8'h7E, 27'h4000000, 27'h0, 4'b0001, 4'b0000);
        accept("zero");
        // A lsb falls out after a 4-bit shift and must set the sticky bit
        run("sticky", 32'h3F800001, 32'h41800000, 1, 8'h83, 8'h04, 27'h4000000, 27'h400001, 4'b0000, 4'b0000);
        accept("sticky");
        run("d26", 32'h3F800000, 32'h4C800000, 1, 8'h99, 8'h1A, 27'h4000000, 27'h1, 4'b0000, 4'b0000);
        accept("d26");

        // Equal magnitude, opposite signs: no swap, A is big
        run("t5", 32'hBF800000, 32'h3F800000, 0, 8'h7F, 8'h00, 27'h4000000, 27'h4000000, 4'b0000, 4'b0000);
        chk("t5_sign_big", sign_big, 1);
        chk("t5_sign_small", sign_small, 0);
        // Start while stalled must not be taken without out_ready
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_mant", mant_small, 27'h4000000);
            chk("t5_hold_sign", sign_big, 1);
            chk("t5_hold_no_load", load_data, 0);
        end
        a_in      = 32'h3F800000;
        b_in      = 32'h40000000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("t5_back2back_load", load_data, 1);
        chk("t5_back2back_valid", out_valid, 0);
        chk("t5_back2back_busy", busy, 1);
        wait_valid("t5b", 4);
        check_res("t5b", 1, 8'h80, 8'h01, 27'h4000000, 27'h2000000, 4'b0000, 4'b0000);
        accept("t5b");

        // Reset mid-fetch on both instances
        a_in   = 32'h7F800000;
        b_in   = 32'h00000000;
        start  = 1'b1;
        start4 = 1'b1;
        tick();
        start  = 1'b0;
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_busy4", busy4, 0);
        chk("t6_load", load_data, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_no_valid", {30'b0, out_valid, out_valid4}, 0);
        end

        // Fresh fetch on both: latencies 2+FETCH_LAT
        a_in   = 32'h40000000;
        b_in   = 32'h3F800000;
        start  = 1'b1;
        start4 = 1'b1;
        tick();
        start  = 1'b0;
        start4 = 1'b0;
        chk("t6_load4", load_data4, 1);
        l2 = -1;
        l4 = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid && l2 < 0) l2 = i;
            if (out_valid4 && l4 < 0) l4 = i;
        end
        chk("t6_lat2", l2, 4);
        chk("t6_lat4", l4, 6);
        check_res("t6", 0, 8'h80, 8'h01, 27'h4000000, 27'h2000000, 4'b0000, 4'b0000);
        chk("t6_swapped4", swapped4, 0);
        chk("t6_exp_big4", exp_big4, 8'h80);
        chk("t6_exp_diff4", exp_diff4, 8'h01);
        chk("t6_mant_big4", mant_big4, 27'h4000000);
        chk("t6_mant_small4", mant_small4, 27'h2000000);
        chk("t6_class4", {class_a4, class_b4}, 8'h00);
        chk("t6_signs4", {sign_big4, sign_small4}, 2'b00);
        accept("t6");
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("t6_valid_drop4", out_valid4, 0);
        chk("t6_idle4", busy4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
